item_code_entry: RTL
====================

ITEM_CODE_ENTRY -- requirements
Module: item_code_entry

Interface
REQ-001 SHALL have parameter ITEM_ADDR_WIDTH, default 10, the width of the issued item address.
REQ-002 SHALL have parameter MAX_DIGITS, default 3, the maximum number of decimal digits per entry.
REQ-003 SHALL have parameter ITEM_COUNT, default 1000, the number of valid items (valid codes 0..ITEM_COUNT-1).
REQ-004 SHALL have parameter ENTRY_TIMEOUT, default 1000000, the number of idle cycles in ENTRY before the entry is abandoned.
REQ-005 SHALL have parameter ACK_TIMEOUT, default 4, the maximum number of cycles to wait for selection_ready.
REQ-006 SHALL use one clock and one reset: clk, input, 1, the single clock, rising-edge active.
REQ-007 SHALL have rst, input, 1, a synchronous active-high reset.
REQ-008 SHALL have key_valid, input, 1, a keypress strobe that is valid for one cycle.
REQ-009 SHALL have key_code, input, 4, where 0-9 = digit, 4'hA = CLEAR, 4'hB = ENTER, and 4'hC-4'hF are ignored.
REQ-010 SHALL have selection_ready, input, 1, the acknowledge pulse from the item selector.
REQ-011 SHALL have item_select, output, ITEM_ADDR_WIDTH, the issued item code.
REQ-012 SHALL have item_select_valid, output, 1, a one-cycle issue strobe.
REQ-013 SHALL have digit_count, output, $clog2(MAX_DIGITS+1), the number of digits accepted so far.
REQ-014 SHALL have entry_busy, output, 1, which is high in every state except IDLE.
REQ-015 SHALL have entry_done, output, 1, a one-cycle pulse on acknowledged issue.
REQ-016 SHALL have entry_error, output, 1, a one-cycle pulse on rejected input.
REQ-017 SHALL have timeout, output, 1, a one-cycle pulse on an entry timeout or an acknowledge timeout.

Function
REQ-018 SHALL implement the states IDLE, ENTRY, ISSUE and WAIT_ACK, with all outputs registered.
REQ-019 SHALL accept a key only in the cycle where key_valid=1, sampled on the rising edge of clk.
REQ-020 SHALL, in IDLE on a digit d, set the accumulator to d, set digit_count to 1, and go to ENTRY.
REQ-021 SHALL, in ENTRY on a digit d with digit_count<MAX_DIGITS, set the accumulator to acc*10+d and increment digit_count.
REQ-022 SHALL size the accumulator to hold 10^MAX_DIGITS-1 with no truncation.
REQ-023 SHALL, in ENTRY on a digit with digit_count==MAX_DIGITS, ignore the digit, pulse entry_error, and leave the accumulator unchanged.
REQ-024 SHALL, on CLEAR in IDLE or ENTRY, zero the accumulator and digit_count, go to IDLE, and not pulse entry_error.
REQ-025 SHALL, on ENTER in IDLE (no digits), pulse entry_error and stay in IDLE.
REQ-026 SHALL, on ENTER in ENTRY with acc>=ITEM_COUNT, pulse entry_error, clear the accumulator and digit_count, and go to IDLE.
REQ-027 SHALL, on ENTER in ENTRY with acc<ITEM_COUNT, load acc into item_select and go to ISSUE.
REQ-028 SHALL drive item_select_valid=1 for exactly one cycle, the cycle after ENTER is sampled, while in ISSUE.
REQ-029 SHALL then move from ISSUE to WAIT_ACK.
REQ-030 SHALL hold item_select stable from issue until the next issue.
REQ-031 SHALL, in WAIT_ACK when selection_ready=1, pulse entry_done, clear the accumulator and digit_count, and go to IDLE.
REQ-032 SHALL, in WAIT_ACK when selection_ready has not arrived within ACK_TIMEOUT cycles of entering WAIT_ACK, pulse timeout, clear the accumulator and digit_count, and go to IDLE.
REQ-033 SHALL, in ENTRY with no accepted key for ENTRY_TIMEOUT consecutive cycles, pulse timeout, clear the accumulator and digit_count, and go to IDLE.
REQ-034 SHALL restart the entry timer on every accepted key.
REQ-035 SHALL give a key priority over the timeout when both occur in the same cycle: the key is processed and the timer restarts.
REQ-036 SHALL ignore keys received in ISSUE or WAIT_ACK without pulsing entry_error.
REQ-037 SHALL ignore selection_ready outside WAIT_ACK.
REQ-038 SHALL silently ignore key codes 4'hC-4'hF in all states without resetting the timer.
REQ-039 SHALL never have more than one of entry_done, entry_error and timeout high in the same cycle.

Reset
REQ-040 SHALL, while rst=1 at a clock edge, set the state to IDLE, set item_select, item_select_valid, digit_count, entry_busy, entry_done, entry_error and timeout to 0, and clear the accumulator and both timers.
REQ-041 SHALL, on reset asserted mid-entry or in WAIT_ACK, abandon the operation with no pulse output, and ignore a key coincident with rst.

Verification
REQ-042 SHALL cover: keys 4,2,7,ENTER -> item_select=427, item_select_valid high for 1 cycle, 1 cycle after ENTER; selection_ready 1 cycle later -> entry_done pulse, digit_count=0.
REQ-043 SHALL cover: keys 1,2,3,4 -> the 4th digit triggers an entry_error pulse, digit_count stays 3; ENTER -> item_select=123.
REQ-044 SHALL cover: ITEM_COUNT=500, keys 6,0,0,ENTER -> entry_error pulse, no item_select_valid, state IDLE; ENTER alone -> entry_error.
REQ-045 SHALL cover: ENTRY_TIMEOUT=8, key 5 then idle for 8 cycles -> timeout pulse, digit_count=0; a key exactly at cycle 8 -> no timeout, digit accepted.
REQ-046 SHALL cover: issue 12 with selection_ready withheld -> timeout pulse after ACK_TIMEOUT cycles; digit keys during WAIT_ACK ignored, with no entry_error.
REQ-047 SHALL cover: keys 9,9 then rst=1 for 1 cycle -> all outputs 0; subsequent keys 3,ENTER -> item_select=3.

Source files
------------

// File: rtl/item_code_entry.sv
// Keypad item-code entry controller: collects up to MAX_DIGITS decimal digits,
// validates the code against ITEM_COUNT, issues it to the item selector and
// waits for its acknowledge. Entry inactivity and a missing acknowledge both
// abandon the transaction with a timeout pulse.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | no digits held, waiting for the first digit
// S_ENTRY    | collecting digits, entry inactivity timer running
// S_ISSUE    | item_select_valid strobe cycle for the accepted code
// S_WAIT_ACK | waiting for selection_ready, acknowledge timer running
module item_code_entry #(
  parameter int ITEM_ADDR_WIDTH = 10,
  parameter int MAX_DIGITS      = 3,
  parameter int ITEM_COUNT      = 1000,
  parameter int ENTRY_TIMEOUT   = 1000000,
  parameter int ACK_TIMEOUT     = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             key_valid,
  input  logic [3:0]                       key_code,
  input  logic                             selection_ready,
  output logic [ITEM_ADDR_WIDTH-1:0]       item_select,
  output logic                             item_select_valid,
  output logic [$clog2(MAX_DIGITS+1)-1:0]  digit_count,
  output logic                             entry_busy,
  output logic                             entry_done,
  output logic                             entry_error,
  output logic                             timeout
);

  // Accumulator holds 10^MAX_DIGITS-1 without truncation.
  localparam int ACC_W = $clog2(10**MAX_DIGITS);
  localparam int DC_W  = $clog2(MAX_DIGITS+1);
  localparam int ET_W  = $clog2(ENTRY_TIMEOUT+1);
  localparam int AT_W  = $clog2(ACK_TIMEOUT+1);
  localparam logic [31:0] ITEM_LIMIT = ITEM_COUNT;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ENTRY    = 2'd1,
    S_ISSUE    = 2'd2,
    S_WAIT_ACK = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [ACC_W-1:0]   acc, acc_n, acc_shift;
  logic [DC_W-1:0]    dc_n;
  logic [ET_W-1:0]    entry_timer, entry_timer_n;
  logic [AT_W-1:0]    ack_timer, ack_timer_n;
  logic [ITEM_ADDR_WIDTH-1:0] sel_n;
  logic               valid_n, done_n, err_n, to_n;
  logic               key_digit, key_clear, key_enter, key_accept;
  logic               acc_out_of_range;

  // Key decode; codes C-F fall through every branch and leave the timer alone.
  always_comb begin
    key_digit        = key_valid && (key_code <= 4'd9);
    key_clear        = key_valid && (key_code == 4'hA);
    key_enter        = key_valid && (key_code == 4'hB);
    key_accept       = key_digit || key_clear || key_enter;
    acc_shift        = (acc * ACC_W'(10)) + ACC_W'(key_code);
    acc_out_of_range = (32'(acc) >= ITEM_LIMIT);
  end

  // Next-state and next-output logic; timers are down-counters that fire at zero.
  always_comb begin
    state_n       = state;
    acc_n         = acc;
    dc_n          = digit_count;
    sel_n         = item_select;
    valid_n       = 1'b0;
    done_n        = 1'b0;
    err_n         = 1'b0;
    to_n          = 1'b0;
    entry_timer_n = entry_timer;
    ack_timer_n   = ack_timer;
    case (state)
      S_IDLE: begin
        if (key_digit) begin
          acc_n         = ACC_W'(key_code);
          dc_n          = DC_W'(1);
          entry_timer_n = ET_W'(ENTRY_TIMEOUT - 1);
          state_n       = S_ENTRY;
        end else if (key_clear) begin
          acc_n = '0;
          dc_n  = '0;
        end else if (key_enter) begin
          err_n = 1'b1;
        end
      end
      S_ENTRY: begin
        if (key_accept) begin
          // A key wins over a coincident timer expiry and restarts the timer.
          entry_timer_n = ET_W'(ENTRY_TIMEOUT - 1);
          if (key_digit) begin
            if (digit_count < DC_W'(MAX_DIGITS)) begin
              acc_n = acc_shift;
              dc_n  = digit_count + DC_W'(1);
            end else begin
              err_n = 1'b1;
            end
          end else if (key_clear) begin
            acc_n   = '0;
            dc_n    = '0;
            state_n = S_IDLE;
          end else begin
            if (acc_out_of_range) begin
              err_n   = 1'b1;
              acc_n   = '0;
              dc_n    = '0;
              state_n = S_IDLE;
            end else begin
              sel_n   = ITEM_ADDR_WIDTH'(acc);
              valid_n = 1'b1;
              state_n = S_ISSUE;
            end
          end
        end else if (entry_timer == '0) begin
          to_n    = 1'b1;
          acc_n   = '0;
          dc_n    = '0;
          state_n = S_IDLE;
        end else begin
          entry_timer_n = entry_timer - ET_W'(1);
        end
      end
      S_ISSUE: begin
        ack_timer_n = AT_W'(ACK_TIMEOUT - 1);
        state_n     = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (selection_ready) begin
          done_n  = 1'b1;
          acc_n   = '0;
          dc_n    = '0;
          state_n = S_IDLE;
        end else if (ack_timer == '0) begin
          to_n    = 1'b1;
          acc_n   = '0;
          dc_n    = '0;
          state_n = S_IDLE;
        end else begin
          ack_timer_n = ack_timer - AT_W'(1);
        end
      end
      default: begin
        acc_n   = '0;
        dc_n    = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; reset abandons everything silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= S_IDLE;
      acc               <= '0;
      digit_count       <= '0;
      item_select       <= '0;
      item_select_valid <= 1'b0;
      entry_busy        <= 1'b0;
      entry_done        <= 1'b0;
      entry_error       <= 1'b0;
      timeout           <= 1'b0;
      entry_timer       <= '0;
      ack_timer         <= '0;
    end else begin
      state             <= state_n;
      acc               <= acc_n;
      digit_count       <= dc_n;
      item_select       <= sel_n;
      item_select_valid <= valid_n;
      entry_busy        <= (state_n != S_IDLE);
      entry_done        <= done_n;
      entry_error       <= err_n;
      timeout           <= to_n;
      entry_timer       <= entry_timer_n;
      ack_timer         <= ack_timer_n;
    end
  end

endmodule
